// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and byte-merge helper for the sram_arb SRAM front end.
package sram_arb_pkg;
  localparam int PKG_DW = 32;
  localparam int PKG_SW = PKG_DW / 8;
  typedef enum logic {IDLE, RMW_WR} state_e;
  typedef enum logic {PORT_IFU = 1'b0, PORT_LSU = 1'b1} port_e;
  typedef struct packed {
    logic [31:0]       addr;
    logic              wen;
    logic [PKG_DW-1:0] wdata;
    logic [PKG_SW-1:0] wstrb;
  } req_t;
  function automatic logic [PKG_DW-1:0] merge_bytes(input logic [PKG_DW-1:0] old_w,
                                                    input logic [PKG_DW-1:0] new_w,
                                                    input logic [PKG_SW-1:0] strb);
    logic [PKG_DW-1:0] m;
    for (int i = 0; i < PKG_SW; i++) m[8*i+:8] = strb[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return m;
  endfunction
endpackage

// File: rtl/sram_arb_rr.sv
// rr_arb2: two-input round-robin arbiter; pointer favours the port not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic r_ptr;
  always_comb gnt = (&req) ? (r_ptr ? 2'b10 : 2'b01) : req;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ptr <= 1'b0;
    else if (advance) r_ptr <= gnt[0];
endmodule

// File: rtl/sram_arb.sv
// sram_arb: two-port round-robin arbiter with read-modify-write for partial stores.
// Optional SRAM_ARB_PERF_EN adds grant/conflict/RMW performance counters.
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = PKG_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_req_vld,
  output logic            p0_req_rdy,
  input  logic [31:0]     p0_req_addr,
  input  logic            p0_req_wen,
  input  logic [DW-1:0]   p0_req_wdata,
  input  logic [DW/8-1:0] p0_req_wstrb,
  output logic            p0_rsp_vld,
  output logic [DW-1:0]   p0_rsp_rdata,
  input  logic            p1_req_vld,
  output logic            p1_req_rdy,
  input  logic [31:0]     p1_req_addr,
  input  logic            p1_req_wen,
  input  logic [DW-1:0]   p1_req_wdata,
  input  logic [DW/8-1:0] p1_req_wstrb,
  output logic            p1_rsp_vld,
  output logic [DW-1:0]   p1_rsp_rdata,
  output logic [AW-1:0]   sram_addr,
  output logic            sram_wen,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0]     perf_grant0,
  output logic [31:0]     perf_grant1,
  output logic [31:0]     perf_conflict,
  output logic [31:0]     perf_rmw
`endif
);
  state_e        r_state, w_next;
  port_e         r_port;
  req_t          r_req, w_req;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_rsp_vld, w_gnt;
  logic          r_rsp_rd, w_idle, w_any, w_rmw, w_full, w_zero, w_unused;
  assign w_idle = (r_state == IDLE) & ~rst;
  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_req_vld, p0_req_vld} & {2{w_idle}}),
    .advance (w_any),
    .gnt     (w_gnt)
  );
  assign w_any  = |w_gnt;
  assign w_req  = w_gnt[1] ? req_t'{p1_req_addr, p1_req_wen, p1_req_wdata, p1_req_wstrb}
                           : req_t'{p0_req_addr, p0_req_wen, p0_req_wdata, p0_req_wstrb};
  assign w_full = &w_req.wstrb;
  assign w_zero = ~|w_req.wstrb;
  assign w_rmw  = w_any & w_req.wen & ~w_full & ~w_zero;
  assign p0_req_rdy = w_gnt[0];
  assign p1_req_rdy = w_gnt[1];
  // Without a grant the address bus parks on its last value.
  assign sram_addr  = w_any ? w_req.addr[AW+1:2] : r_addr;
  assign sram_wen   = ~rst & ((r_state == RMW_WR) | (w_any & w_req.wen & w_full));
  assign sram_wdata = (r_state == RMW_WR) ? merge_bytes(sram_rdata, r_req.wdata, r_req.wstrb)
                                          : (w_any ? w_req.wdata : '0);
  assign p0_rsp_vld   = r_rsp_vld[0];
  assign p1_rsp_vld   = r_rsp_vld[1];
  assign p0_rsp_rdata = (r_rsp_vld[0] & r_rsp_rd) ? sram_rdata : '0;
  assign p1_rsp_rdata = (r_rsp_vld[1] & r_rsp_rd) ? sram_rdata : '0;
  assign w_unused = ^{w_req.addr[31:AW+2], w_req.addr[1:0], r_req.addr, r_req.wen};
  always_comb w_next = (r_state == IDLE && w_rmw) ? RMW_WR : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_port    <= PORT_IFU;
      r_req     <= '0;
      r_addr    <= '0;
      r_rsp_vld <= '0;
      r_rsp_rd  <= 1'b0;
    end else begin
      r_addr   <= sram_addr;
      r_rsp_rd <= w_any & ~w_req.wen;
      // A partial store acks only after its write-back cycle.
      r_rsp_vld <= (r_state == RMW_WR) ? ((r_port == PORT_LSU) ? 2'b10 : 2'b01)
                                       : (w_rmw ? 2'b00 : w_gnt);
      if (w_rmw) begin
        r_port <= port_e'(w_gnt[1]);
        r_req  <= w_req;
      end
    end
`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
      perf_rmw      <= '0;
    end else begin
      perf_grant0   <= perf_grant0 + 32'(w_gnt[0]);
      perf_grant1   <= perf_grant1 + 32'(w_gnt[1]);
      perf_conflict <= perf_conflict + 32'(r_state == IDLE && p0_req_vld && p1_req_vld);
      perf_rmw      <= perf_rmw + 32'(w_rmw);
    end
`endif
endmodule
